// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side signal bundle for mem_arbiter.
//   icache : iREN, iaddr -> arbiter ; iwait, iload <- arbiter
//   dcache : dREN, dWEN, daddr, dstore -> arbiter ; dwait, dload <- arbiter
//   RAM    : ramREN, ramWEN, ramaddr, ramstore <- arbiter ; ramload, ramstate -> arbiter
// Modport slave is the arbiter's view; modport master is the view of the
// environment (caches plus RAM model) that surrounds it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [31:0]       iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [31:0]       dstore;
    logic              dwait;
    logic [31:0]       dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: memory-side responder for an icache/dcache pair sharing one
// single-ported, variable-latency RAM.
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave carrying the cache request/wait/data
//          signals and the RAM enable/address/data/state signals
// Data requests normally win; an icache read that has watched STARVE_LIMIT
// dcache completions go by is granted next. A transaction's address and
// write data are captured at grant, so the caches may change their inputs
// while it is in flight.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int          ADDR_W       = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        IFETCH,
        DREAD,
        DWRITE
    } state_t;

    state_t            state;
    state_t            next;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_next;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       store_q;
    logic              access;
    logic              error;

    assign access = (bus.ramstate == RAM_ACCESS);
    assign error  = (bus.ramstate == RAM_ERROR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            store_q    <= '0;
        end else begin
            state      <= next;
            starve_cnt <= starve_next;
            if (state == IDLE && next != IDLE) begin
                addr_q <= (next == IFETCH) ? bus.iaddr : bus.daddr;
                if (next == DWRITE) begin
                    store_q <= bus.dstore;
                end
            end
        end
    end

    // RAM enables and cache completions are decoded from the registered
    // state, so reset drops them without waiting for a clock edge.
    always_comb begin
        next         = state;
        starve_next  = starve_cnt;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (!bus.iREN) begin
                    starve_next = '0;
                end
                if (bus.iREN && starve_cnt == LIMIT) begin
                    next = IFETCH;
                end else if (bus.dWEN) begin
                    next = DWRITE;
                end else if (bus.dREN) begin
                    next = DREAD;
                end else if (bus.iREN) begin
                    next = IFETCH;
                end
            end

            IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = addr_q;
                // Completion takes precedence over a same-cycle withdrawal.
                if (access) begin
                    bus.iwait   = 1'b0;
                    bus.iload   = bus.ramload;
                    starve_next = '0;
                    next        = IDLE;
                end else if (error || !bus.iREN) begin
                    next = IDLE;
                end
            end

            DREAD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = addr_q;
                if (access) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                    if (bus.iREN && starve_cnt != LIMIT) begin
                        starve_next = starve_cnt + 4'd1;
                    end
                    next = IDLE;
                end else if (error || !bus.dREN) begin
                    next = IDLE;
                end
            end

            DWRITE: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = addr_q;
                bus.ramstore = store_q;
                if (access) begin
                    bus.dwait = 1'b0;
                    if (bus.iREN && starve_cnt != LIMIT) begin
                        starve_next = starve_cnt + 4'd1;
                    end
                    next = IDLE;
                end else if (error || !bus.dWEN) begin
                    next = IDLE;
                end
            end

            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbiter.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        CLK;
    logic        RST;
    logic        use_hash;
    logic [31:0] ramload_d;
    int          checks;
    int          errors;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .ADDR_W(32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    function automatic logic [31:0] h(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // RAM read data: fixed value for directed tests, address hash for random.
    assign bus.ramload = use_hash ? h(bus.ramaddr) : ramload_d;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = 2'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1; use_hash = 1'b0; ramload_d = 32'hA5A5A5A5;
        idle_inputs();
        #2;
        checks++;
        if ({bus.iwait, bus.dwait} !== 2'b11) begin
            errors++; $display("FAIL reset_waits: got %b want 11", {bus.iwait, bus.dwait});
        end
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== 66'd0) begin
            errors++; $display("FAIL reset_ram: ren=%b wen=%b addr=%h store=%h want all 0",
                               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        checks++;
        if ({bus.iload, bus.dload} !== 64'd0) begin
            errors++; $display("FAIL reset_loads: iload=%h dload=%h want 0", bus.iload, bus.dload);
        end
        #10 RST = 1'b0;
    endtask

    task automatic test_single_fetch();
        ramload_d = 32'h8C010004;
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h40; #1;
        checks++;
        if (bus.ramREN !== 1'b0) begin
            errors++; $display("FAIL fetch_idle_ren: got %b want 0", bus.ramREN);
        end
        tick(); bus.ramstate = 2'd1; bus.iaddr = 32'h99; #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload} !== {1'b1, 1'b0, 32'h40, 1'b1, 32'h0}) begin
            errors++; $display("FAIL fetch_busy: ren=%b wen=%b addr=%h iwait=%b iload=%h want 1 0 40 1 0",
                               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.iload);
        end
        tick(); bus.ramstate = 2'd2; #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload, bus.dwait} !== {1'b1, 32'h40, 1'b0, 32'h8C010004, 1'b1}) begin
            errors++; $display("FAIL fetch_done: ren=%b addr=%h iwait=%b iload=%h dwait=%b want 1 40 0 8c010004 1",
                               bus.ramREN, bus.ramaddr, bus.iwait, bus.iload, bus.dwait);
        end
        tick(); bus.iREN = 1'b0; bus.ramstate = 2'd0; #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload} !== {1'b0, 32'h0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL fetch_after: ren=%b addr=%h iwait=%b iload=%h want 0 0 1 0",
                               bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
        end
    endtask

    task automatic test_simultaneous();
        ramload_d = 32'h11112222;
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h80; #1;
        tick(); bus.ramstate = 2'd2; #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.dwait, bus.dload, bus.iwait} !== {1'b1, 32'h80, 1'b0, 32'h11112222, 1'b1}) begin
            errors++; $display("FAIL simul_dread: ren=%b addr=%h dwait=%b dload=%h iwait=%b want 1 80 0 11112222 1",
                               bus.ramREN, bus.ramaddr, bus.dwait, bus.dload, bus.iwait);
        end
        tick(); bus.dREN = 1'b0; bus.ramstate = 2'd0; #1;
        checks++;
        if ({bus.ramREN, bus.dwait, bus.iwait} !== 3'b011) begin
            errors++; $display("FAIL simul_gap: ren=%b dwait=%b iwait=%b want 0 1 1",
                               bus.ramREN, bus.dwait, bus.iwait);
        end
        tick(); bus.ramstate = 2'd2; ramload_d = 32'h33334444; #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.iwait, bus.iload} !== {1'b1, 32'h44, 1'b0, 32'h33334444}) begin
            errors++; $display("FAIL simul_ifetch: ren=%b addr=%h iwait=%b iload=%h want 1 44 0 33334444",
                               bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
        end
        tick(); bus.iREN = 1'b0; bus.ramstate = 2'd0; #1;
    endtask

    task automatic test_write_priority();
        tick(); bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; #1;
        tick(); bus.ramstate = 2'd1; bus.dstore = 32'h0; bus.daddr = 32'h7; #1;
        checks++;
        if ({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait} !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1}) begin
            errors++; $display("FAIL write_busy: wen=%b ren=%b addr=%h store=%h dwait=%b want 1 0 100 deadbeef 1",
                               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait);
        end
        tick(); bus.ramstate = 2'd2; ramload_d = 32'hFFFFFFFF; #1;
        checks++;
        if ({bus.ramWEN, bus.dwait, bus.dload} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL write_done: wen=%b dwait=%b dload=%h want 1 0 0",
                               bus.ramWEN, bus.dwait, bus.dload);
        end
        tick(); bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = 2'd0; #1;
        checks++;
        if ({bus.ramWEN, bus.ramstore, bus.dwait} !== {1'b0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL write_after: wen=%b store=%h dwait=%b want 0 0 1",
                               bus.ramWEN, bus.ramstore, bus.dwait);
        end
    endtask

    task automatic test_starvation();
        int d_before_i;
        int i_seen;
        int after_i;
        d_before_i = 0; i_seen = 0; after_i = 0;
        tick(); bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h10; bus.daddr = 32'h20; bus.ramstate = 2'd2; #1;
        for (int c = 0; c < 40 && after_i == 0; c++) begin
            tick(); #1;
            if (!bus.iwait) i_seen++;
            if (!bus.dwait) begin
                if (i_seen == 0) d_before_i++;
                else after_i = 1;
            end
        end
        checks++;
        if (d_before_i !== LIMIT) begin
            errors++; $display("FAIL starve_dcount: got %0d dcache completions want %0d", d_before_i, LIMIT);
        end
        checks++;
        if (i_seen !== 1 || after_i !== 1) begin
            errors++; $display("FAIL starve_clear: ifetches=%0d dafter=%0d want 1 1", i_seen, after_i);
        end
        tick(); idle_inputs(); #1;
        tick(); #1;
    endtask

    task automatic test_error_retry();
        tick(); bus.dREN = 1'b1; bus.daddr = 32'h200; #1;
        tick(); bus.ramstate = 2'd3; #1;
        checks++;
        if ({bus.ramREN, bus.dwait, bus.dload} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_cycle: ren=%b dwait=%b dload=%h want 1 1 0",
                               bus.ramREN, bus.dwait, bus.dload);
        end
        tick(); bus.ramstate = 2'd0; #1;
        checks++;
        if ({bus.ramREN, bus.dwait} !== 2'b01) begin
            errors++; $display("FAIL err_idle: ren=%b dwait=%b want 0 1", bus.ramREN, bus.dwait);
        end
        tick(); bus.ramstate = 2'd2; ramload_d = 32'hCAFEF00D; #1;
        checks++;
        if ({bus.ramREN, bus.ramaddr, bus.dwait, bus.dload} !== {1'b1, 32'h200, 1'b0, 32'hCAFEF00D}) begin
            errors++; $display("FAIL err_retry: ren=%b addr=%h dwait=%b dload=%h want 1 200 0 cafef00d",
                               bus.ramREN, bus.ramaddr, bus.dwait, bus.dload);
        end
        tick(); idle_inputs(); #1;
    endtask

    task automatic test_abort();
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h300; #1;
        tick(); bus.ramstate = 2'd1; #1;
        checks++;
        if (bus.ramREN !== 1'b1) begin
            errors++; $display("FAIL abort_serving: ren=%b want 1", bus.ramREN);
        end
        tick(); bus.iREN = 1'b0; #1;
        tick(); bus.ramstate = 2'd2; #1;
        checks++;
        if ({bus.ramREN, bus.iwait, bus.iload} !== {1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL abort_idle: ren=%b iwait=%b iload=%h want 0 1 0",
                               bus.ramREN, bus.iwait, bus.iload);
        end
        tick(); idle_inputs(); #1;
    endtask

    task automatic test_reset_midwrite();
        tick(); bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h12345678; #1;
        tick(); bus.ramstate = 2'd1; #1;
        checks++;
        if (bus.ramWEN !== 1'b1) begin
            errors++; $display("FAIL rst_pre: wen=%b want 1", bus.ramWEN);
        end
        RST = 1'b1; #1;
        checks++;
        if ({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait} !== {2'b00, 64'h0, 2'b11}) begin
            errors++; $display("FAIL rst_async: wen=%b ren=%b addr=%h store=%h iwait=%b dwait=%b want 0 0 0 0 1 1",
                               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait);
        end
        bus.dWEN = 1'b0;
        tick(); RST = 1'b0; bus.ramstate = 2'd0;
        tick(); #1;
        checks++;
        if ({bus.ramWEN, bus.dwait} !== 2'b01) begin
            errors++; $display("FAIL rst_after: wen=%b dwait=%b want 0 1", bus.ramWEN, bus.dwait);
        end
    endtask

    // Reference model: at most one granted transaction (kind 0 none, 1 fetch,
    // 2 read, 3 write) with the address/data captured when it was chosen.
    task automatic test_random();
        int          kind;
        logic [31:0] t_addr;
        logic [31:0] t_data;
        int          starve;
        int          r;
        int          completions;
        logic        done;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        logic        e_iwait, e_dwait, e_ren, e_wen;
        kind = 0; t_addr = '0; t_data = '0; starve = 0; completions = 0;
        use_hash = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 3) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(0, 3) == 0) bus.dREN = ~bus.dREN;
            if ($urandom_range(0, 5) == 0) bus.dWEN = ~bus.dWEN;
            bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
            r = $urandom_range(0, 9);
            bus.ramstate = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            #1;
            done    = (kind != 0) && (bus.ramstate == 2'd2);
            e_ren   = (kind == 1) || (kind == 2);
            e_wen   = (kind == 3);
            e_addr  = (kind != 0) ? t_addr : 32'h0;
            e_store = (kind == 3) ? t_data : 32'h0;
            e_iwait = !(done && kind == 1);
            e_dwait = !(done && kind >= 2);
            e_iload = (done && kind == 1) ? h(t_addr) : 32'h0;
            e_dload = (done && kind == 2) ? h(t_addr) : 32'h0;
            checks++;
            if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== {e_ren, e_wen, e_addr, e_store}) begin
                errors++; $display("FAIL rand_ram c=%0d: ren=%b wen=%b addr=%h store=%h want %b %b %h %h",
                                   c, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, e_ren, e_wen, e_addr, e_store);
            end
            checks++;
            if ({bus.iwait, bus.iload, bus.dwait, bus.dload} !== {e_iwait, e_iload, e_dwait, e_dload}) begin
                errors++; $display("FAIL rand_cache c=%0d: iwait=%b iload=%h dwait=%b dload=%h want %b %h %b %h",
                                   c, bus.iwait, bus.iload, bus.dwait, bus.dload, e_iwait, e_iload, e_dwait, e_dload);
            end
            if (done) completions++;
            // Advance the model across the coming clock edge.
            if (kind == 0) begin
                if (bus.iREN && starve == LIMIT) kind = 1;
                else if (bus.dWEN) kind = 3;
                else if (bus.dREN) kind = 2;
                else if (bus.iREN) kind = 1;
                t_addr = (kind == 1) ? bus.iaddr : bus.daddr;
                t_data = bus.dstore;
                if (!bus.iREN) starve = 0;
            end else if (done) begin
                if (kind == 1) starve = 0;
                else if (bus.iREN && starve < LIMIT) starve++;
                kind = 0;
            end else if (bus.ramstate == 2'd3 || (kind == 1 && !bus.iREN) ||
                         (kind == 2 && !bus.dREN) || (kind == 3 && !bus.dWEN)) begin
                kind = 0;
            end
        end
        checks++;
        if (completions < 100) begin
            errors++; $display("FAIL rand_activity: got %0d completions want >= 100", completions);
        end
        tick(); idle_inputs(); use_hash = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_write_priority();
        test_starvation();
        test_error_retry();
        test_abort();
        test_reset_midwrite();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
